// File: rtl/serial_capture_playback.sv
// serial_capture_playback: deserialises framed words from serial_in into an external
// single-port RAM (ram_we/ram_addr/ram_wdata, ram_rdata after RD_LAT cycles) and replays them
// on send through out_data/out_valid/out_ready; busy, stored_count, overflow (sticky), par_err.
// Optional macro PARITY_CHECK_EN: even parity bit after each word, bad frames dropped.
module serial_capture_playback #(
  parameter int WORD_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              send,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [ADDR_W:0]   stored_count,
  output logic              overflow,
  output logic              par_err
);

`ifdef PARITY_CHECK_EN
  localparam int NB = WORD_W + 1;
`else
  localparam int NB = WORD_W;
`endif
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(NB + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, RX_BITS, RX_STORE, TX_ADDR, TX_WAIT, TX_OUT
  } state_t;

  state_t            state;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [LW-1:0]     wait_cnt;
  logic [NB-1:0]     shreg;
  logic [NB-1:0]     shnext;
  logic [ADDR_W-1:0] rd_ptr;
  logic              send_q;
  logic              full;
  logic              par_ok;
  logic [ADDR_W:0]   depth_c;

  assign depth_c = {1'b1, {ADDR_W{1'b0}}};
  assign shnext  = {serial_in, shreg[NB-1:1]};
  assign full    = (stored_count == depth_c);
  assign busy    = (state != IDLE);

`ifdef PARITY_CHECK_EN
  assign par_ok = ~^shnext;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      shreg        <= '0;
      rd_ptr       <= '0;
      send_q       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      stored_count <= '0;
      overflow     <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      if (send) send_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (serial_in) begin
            state   <= RX_BITS;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else if (send_q) begin
            state    <= TX_ADDR;
            send_q   <= 1'b0;
            rd_ptr   <= '0;
            ram_addr <= '0;
          end
        end
        RX_BITS: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            shreg   <= shnext;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(NB - 1)) begin
              state <= RX_STORE;
              // full outranks a parity failure
              if (full) begin
                overflow <= 1'b1;
              end else if (!par_ok) begin
                par_err <= 1'b1;
              end else begin
                ram_we    <= 1'b1;
                ram_addr  <= stored_count[ADDR_W-1:0];
                ram_wdata <= shnext[WORD_W-1:0];
              end
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STORE: begin
          if (ram_we) stored_count <= stored_count + 1'b1;
          ram_we  <= 1'b0;
          par_err <= 1'b0;
          state   <= IDLE;
        end
        TX_ADDR: begin
          if (stored_count == '0) begin
            state <= IDLE;
          end else begin
            state    <= TX_WAIT;
            wait_cnt <= '0;
          end
        end
        TX_WAIT: begin
          if (wait_cnt == LW'(RD_LAT - 1)) begin
            out_data  <= ram_rdata;
            out_valid <= 1'b1;
            state     <= TX_OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TX_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if ({1'b0, rd_ptr} == stored_count - 1'b1) begin
              state <= IDLE;
            end else begin
              rd_ptr   <= rd_ptr + 1'b1;
              ram_addr <= rd_ptr + 1'b1;
              state    <= TX_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_capture_playback.sv
// tb_serial_capture_playback: directed bench for serial_capture_playback
// with a behavioural RAM of configurable read latency.
module tb_serial_capture_playback;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 2;
  localparam int CPB    = 1;
  localparam int RD_LAT = 2;
`ifdef PARITY_CHECK_EN
  localparam int NB = WORD_W + 1;
`else
  localparam int NB = WORD_W;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              serial_in = 1'b0;
  logic              send = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [ADDR_W:0]   stored_count;
  logic              overflow;
  logic              par_err;

  int n_tests = 0;
  int n_fail  = 0;

  serial_capture_playback #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W),
    .CLKS_PER_BIT(CPB), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .serial_in(serial_in), .send(send),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy),
    .stored_count(stored_count),
    .overflow(overflow), .par_err(par_err)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] mem [1<<ADDR_W];
  logic [WORD_W-1:0] pipe [RD_LAT];
  assign ram_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int wr_addr_q[$];
  int wr_data_q[$];
  int out_q[$];
  int out_addr_q[$];
  int n_perr = 0;
  int n_vld  = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(int'(ram_addr));
      wr_data_q.push_back(int'(ram_wdata));
    end
    if (out_valid && out_ready) begin
      out_q.push_back(int'(out_data));
      out_addr_q.push_back(int'(ram_addr));
    end
    if (out_valid) n_vld++;
    if (par_err) n_perr++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    serial_in = 1'b0;
    send      = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    out_q.delete();
    out_addr_q.delete();
    n_vld = 0;
  endtask

  task automatic send_frame(input logic [15:0] w, input int send_at, input bit bad);
    logic [16:0] f;
    f = {^w ^ bad, w};
    tick;
    serial_in = 1'b1;
    for (int k = 0; k < NB; k++) begin
      tick;
      serial_in = f[k];
      send = (k == send_at);
      repeat (CPB - 1) tick;
    end
    tick;
    serial_in = 1'b0;
    send = 1'b0;
    tick;
  endtask

  task automatic pulse_send;
    tick;
    send = 1'b1;
    tick;
    send = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_tests++;
    if ({ram_we, ram_addr, ram_wdata, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_ram_out got %h %h %h %h want 0", ram_we, ram_addr, ram_wdata, out_data);
    end
    n_tests++;
    if ({out_valid, busy, overflow, par_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {out_valid, busy, overflow, par_err});
    end
    n_tests++;
    if (stored_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", stored_count);
    end
  endtask

  task automatic test_single_frame;
    do_reset;
    send_frame(16'h1234, -1, 1'b0);
    n_tests++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] != 'h1234) begin
      n_fail++;
      $display("FAIL single_write got n=%0d a=%p d=%p want n=1 a=0 d=1234",
               wr_addr_q.size(), wr_addr_q, wr_data_q);
    end
    n_tests++;
    if (stored_count !== 3'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_count got %0d busy=%b want 1 busy=0", stored_count, busy);
    end
  endtask

  task automatic test_playback;
    bit ok;
    do_reset;
    send_frame(16'hA5A5, -1, 1'b0);
    send_frame(16'h0F0F, -1, 1'b0);
    send_frame(16'hBEEF, -1, 1'b0);
    out_ready = 1'b1;
    pulse_send;
    wait_idle(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL playback_timeout busy=%b want 0", busy);
    end
    n_tests++;
    if (out_q.size() != 3 || out_q[0] != 'hA5A5 || out_q[1] != 'h0F0F || out_q[2] != 'hBEEF) begin
      n_fail++;
      $display("FAIL playback_data got %p want a5a5 0f0f beef", out_q);
    end
    n_tests++;
    if (out_addr_q.size() != 3 || out_addr_q[0] != 0 || out_addr_q[1] != 1 || out_addr_q[2] != 2) begin
      n_fail++;
      $display("FAIL playback_addr got %p want 0 1 2", out_addr_q);
    end
    n_tests++;
    if (stored_count !== 3'd3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL playback_count got %0d vld=%b want 3 vld=0", stored_count, out_valid);
    end
  endtask

  task automatic test_stall;
    bit ok;
    bit stable;
    do_reset;
    send_frame(16'h1111, -1, 1'b0);
    send_frame(16'h2222, -1, 1'b0);
    pulse_send;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_first_valid got vld=%b want 1", out_valid);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (out_valid !== 1'b1 || out_data !== 16'h1111 || ram_addr !== 2'd0) stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL stall_hold got vld=%b d=%h a=%0d want 1 1111 0", out_valid, out_data, ram_addr);
    end
    out_ready = 1'b1;
    wait_idle(ok);
    n_tests++;
    if (!ok || out_q.size() != 2 || out_q[0] != 'h1111 || out_q[1] != 'h2222) begin
      n_fail++;
      $display("FAIL stall_release got ok=%b %p want 1111 2222", ok, out_q);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    do_reset;
    for (int i = 1; i <= 4; i++) send_frame(16'(i * 'h0101), -1, 1'b0);
    n_tests++;
    if (overflow !== 1'b0 || stored_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_no_ovf got ovf=%b n=%0d want 0 4", overflow, stored_count);
    end
    send_frame(16'h0505, -1, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || stored_count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow got ovf=%b n=%0d want 1 4", overflow, stored_count);
    end
    n_tests++;
    if (wr_addr_q.size() != 4 || wr_addr_q[3] != 3 || wr_data_q[3] != 'h0404) begin
      n_fail++;
      $display("FAIL ovf_writes got a=%p d=%p want 4 writes last a=3 d=0404", wr_addr_q, wr_data_q);
    end
    out_ready = 1'b1;
    pulse_send;
    wait_idle(ok);
    n_tests++;
    if (!ok || out_q.size() != 4 || out_q[0] != 'h0101 || out_q[3] != 'h0404 || out_addr_q[3] != 3) begin
      n_fail++;
      $display("FAIL full_playback got ok=%b d=%p a=%p want 0101..0404 a 0..3", ok, out_q, out_addr_q);
    end
  endtask

  task automatic test_send_midframe;
    bit ok;
    do_reset;
    send_frame(16'hCAFE, -1, 1'b0);
    send_frame(16'h0042, -1, 1'b0);
    send_frame(16'h00C3, 5, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    n_tests++;
    if (!ok || out_data !== 16'hCAFE || stored_count !== 3'd3) begin
      n_fail++;
      $display("FAIL midframe_play got ok=%b d=%h n=%0d want 1 cafe 3", ok, out_data, stored_count);
    end
    n_tests++;
    if (wr_addr_q.size() != 3 || wr_addr_q[2] != 2 || wr_data_q[2] != 'h00C3) begin
      n_fail++;
      $display("FAIL midframe_store got a=%p d=%p want a=2 d=00c3", wr_addr_q, wr_data_q);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || stored_count !== '0) begin
      n_fail++;
      $display("FAIL abort_reset got vld=%b busy=%b n=%0d want 0 0 0", out_valid, busy, stored_count);
    end
  endtask

  task automatic test_empty_playback;
    bit ok;
    do_reset;
    out_ready = 1'b1;
    pulse_send;
    wait_idle(ok);
    repeat (3) tick;
    n_tests++;
    if (!ok || n_vld != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_playback got ok=%b vld_cycles=%0d busy=%b want 1 0 0", ok, n_vld, busy);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity;
    do_reset;
    n_perr = 0;
    send_frame(16'h0001, -1, 1'b1);
    n_tests++;
    if (n_perr != 1 || wr_addr_q.size() != 0 || stored_count !== '0) begin
      n_fail++;
      $display("FAIL parity_bad got perr=%0d wr=%0d n=%0d want 1 0 0", n_perr, wr_addr_q.size(), stored_count);
    end
    send_frame(16'h0003, -1, 1'b0);
    n_tests++;
    if (n_perr != 1 || stored_count !== 3'd1 || wr_data_q.size() != 1 || wr_data_q[0] != 'h0003) begin
      n_fail++;
      $display("FAIL parity_good got perr=%0d n=%0d d=%p want 1 1 0003", n_perr, stored_count, wr_data_q);
    end
  endtask
`else
  task automatic test_parity;
    n_tests++;
    if (n_perr != 0) begin
      n_fail++;
      $display("FAIL par_err_tied got %0d pulses want 0", n_perr);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_playback;
    test_stall;
    test_overflow;
    test_send_midframe;
    test_empty_playback;
    test_parity;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
